// File: rtl/kd_pkg.sv
// Shared constants, debounce state type, keypad decode and 7-segment table
// for the keypad-to-display block.
package kd_pkg;

  localparam logic [3:0] NO_KEY = 4'b1111;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int REFRESH_DIV_DEFAULT     = 8;

  typedef enum logic {
    DB_IDLE    = 1'b0,
    DB_PRESSED = 1'b1
  } db_state_e;

  // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the least significant slot.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Keypad scan code to hex digit; digit D has no key on this pad.
  function automatic logic [3:0] key_map(input logic [3:0] code);
    logic [3:0] digit;
    case (code)
      4'b0000: digit = 4'h1;
      4'b0001: digit = 4'h2;
      4'b0010: digit = 4'h3;
      4'b0011: digit = 4'hA;
      4'b0100: digit = 4'h4;
      4'b0101: digit = 4'h5;
      4'b0110: digit = 4'h6;
      4'b0111: digit = 4'hB;
      4'b1000: digit = 4'h7;
      4'b1001: digit = 4'h8;
      4'b1010: digit = 4'h9;
      4'b1011: digit = 4'hC;
      4'b1100: digit = 4'hE;
      4'b1101: digit = 4'h0;
      4'b1110: digit = 4'hF;
      default: digit = 4'h0;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/kd_debounce.sv
// Synchronizes the raw keypad code and turns a stable press into exactly one
// key event; the key must be released (stable NO_KEY) before another event.
module kd_debounce
  import kd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] code,
  output logic       key_event,
  output logic [3:0] value
);

  // key_event is a one-cycle strobe with no back-pressure: value is valid in
  // the same cycle key_event is high and holds until the next event.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYCLES);

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    cur_code;
  logic [CW-1:0] cnt;
  db_state_e     state;
  db_state_e     state_next;
  logic          stable;
  logic          fire;

  assign stable = (sync2 == cur_code) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= NO_KEY;
      sync2     <= NO_KEY;
      cur_code  <= NO_KEY;
      cnt       <= '0;
      state     <= DB_IDLE;
      key_event <= 1'b0;
      value     <= NO_KEY;
    end else begin
      sync1     <= code;
      sync2     <= sync1;
      state     <= state_next;
      key_event <= fire;
      if (fire) value <= cur_code;
      // Any code change restarts the count; the count saturates so a held
      // code can never satisfy the stability condition a second time.
      if (sync2 != cur_code) begin
        cur_code <= sync2;
        cnt      <= '0;
      end else if (cnt != CNT_FULL) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    case (state)
      DB_IDLE: begin
        if (stable && (cur_code != NO_KEY)) begin
          fire       = 1'b1;
          state_next = DB_PRESSED;
        end
      end
      DB_PRESSED: begin
        if (stable && (cur_code == NO_KEY)) state_next = DB_IDLE;
      end
      default: state_next = DB_IDLE;
    endcase
  end

endmodule

// File: rtl/top_kd.sv
// Keypad entry into a 4-digit hex shift register shown on a multiplexed
// active-low 7-segment display.
module top_kd
  import kd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REFRESH_DIV     = REFRESH_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [15:0]   number;
  logic          key_event;
  logic [3:0]    key_value;
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    nibble;

  kd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .code     (key_in),
    .key_event(key_event),
    .value    (key_value)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      number <= 16'h0000;
    end else if (key_event) begin
      number <= {number[11:0], key_map(key_value)};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  assign nibble = number[{digit_idx, 2'b00} +: 4];

  // Both outputs come straight from flops loaded on the same edge, so the
  // digit enable and its pattern always switch together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'b1110;
      seg <= SEG_TABLE[0];
    end else begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= SEG_TABLE[nibble];
    end
  end

endmodule

// File: tb/tb_top_kd.sv
// Directed bench for top_kd: reset values, debounce latency/one-shot behaviour,
// glitch rejection, digit shifting, reset mid-press and display scan order.
module tb_top_kd;
  import kd_pkg::*;

  localparam int D = 16;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_in = 4'b1111;
  logic [6:0] seg;
  logic [3:0] an;

  int          n_checks = 0;
  int          n_errors = 0;
  int          updates;
  int          first_chg;
  logic [15:0] last_num;
  logic [15:0] exp_q[$];

  top_kd #(
    .DEBOUNCE_CYCLES(D),
    .REFRESH_DIV    (R)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .key_in(key_in),
    .seg   (seg),
    .an    (an)
  );

  // clock / reset
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic mon_clear();
    updates   = 0;
    first_chg = -1;
    last_num  = dut.number;
  endtask

  // Hold a code for a number of cycles, tracking every change of number.
  task automatic drive(input logic [3:0] code, input int cycles);
    key_in = code;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (dut.number !== last_num) begin
        updates++;
        if (first_chg < 0) first_chg = i;
        last_num = dut.number;
      end
    end
  endtask

  initial begin
    logic [3:0] codes[5];
    logic [3:0] exp_an[4];
    logic [3:0] prev_an;
    int         seen0;
    int         seen1;
    logic       found;

    // reset
    rst = 1'b0;
    key_in = 4'b1111;
    #100;
    check("rst_number", dut.number, 16'h0000);
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'b1000000);
    check("rst_state", dut.u_debounce.state, DB_IDLE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_number", dut.number, 16'h0000);
    check("post_rst_an", an, 4'b1110);
    check("post_rst_seg", seg, 7'b1000000);

    // first press: 0010 -> digit 3
    mon_clear();
    drive(4'b0010, 100);
    check("p1_latency", (first_chg >= 2 + D) && (first_chg <= 2 + D + 2), 1);
    drive(4'b1111, 100);
    check("p1_updates", updates, 1);
    check("p1_number", dut.number, 16'h0003);

    // second press: 1101 -> digit 0
    mon_clear();
    drive(4'b1101, 100);
    drive(4'b1111, 100);
    check("p2_updates", updates, 1);
    check("p2_number", dut.number, 16'h0030);

    seen0 = 0;
    seen1 = 0;
    for (int i = 0; i < 4 * R; i++) begin
      @(negedge clk);
      if (an == 4'b1101) begin
        seen1++;
        check("scan_digit1_seg", seg, 7'b0110000);
      end
      if (an == 4'b1110) begin
        seen0++;
        check("scan_digit0_seg", seg, 7'b1000000);
      end
    end
    check("scan_digit1_slots", seen1, R);
    check("scan_digit0_slots", seen0, R);

    // glitch press shorter than the debounce window
    mon_clear();
    drive(4'b1000, D - 2);
    drive(4'b1111, 100);
    check("glitch_press_updates", updates, 0);
    check("glitch_press_number", dut.number, 16'h0030);

    // long hold with a short release glitch inside it
    mon_clear();
    drive(4'b1000, 500);
    drive(4'b1111, D - 2);
    drive(4'b1000, 500);
    drive(4'b1111, 100);
    check("hold_updates", updates, 1);
    check("hold_number", dut.number, 16'h0307);

    // five presses, oldest digit falls off the left
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101};
    exp_q.push_back(16'h3071);
    exp_q.push_back(16'h0712);
    exp_q.push_back(16'h7123);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h2345);
    mon_clear();
    for (int k = 0; k < 5; k++) begin
      drive(codes[k], 100);
      drive(4'b1111, 100);
      check("five_press_number", dut.number, exp_q.pop_front());
    end
    check("five_press_updates", updates, 5);

    // reset asserted mid-press, key still held after release
    drive(4'b0110, 10);
    #3;
    rst = 1'b0;
    #3;
    check("midrst_number", dut.number, 16'h0000);
    check("midrst_an", an, 4'b1110);
    check("midrst_seg", seg, 7'b1000000);
    check("midrst_state", dut.u_debounce.state, DB_IDLE);
    mon_clear();
    drive(4'b0110, 5);
    check("midrst_no_event", updates, 0);
    rst = 1'b1;
    mon_clear();
    drive(4'b0110, 60);
    check("midrst_relatch", (first_chg >= 2 + D) && (first_chg <= 2 + D + 2), 1);
    check("midrst_updates", updates, 1);
    check("midrst_number", dut.number, 16'h0006);
    drive(4'b1111, 100);

    // scan order over one full refresh cycle
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    prev_an = an;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev_an == 4'b0111) found = 1'b1;
      else prev_an = an;
    end
    check("scan_sync", found, 1);
    if (found) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < R; c++) begin
          if (s != 0 || c != 0) @(negedge clk);
          check("scan_order", an, exp_an[s]);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/top_kd.md
TOP_KD -- requirements
Module: top_kd

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a key press or a key release.
REQ-002 Parameter REFRESH_DIV, default 8: clock cycles each display digit stays enabled.
REQ-003 Port clk, input, 1 bit: single system clock (50 MHz nominal); all state on rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port key_in, input, 4 bits: keypad code, asynchronous to clk; 4'b1111 = no key.
REQ-006 Port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-007 Port an, output, 4 bits: digit enables, active-low, one-hot; an[0] = rightmost digit.
REQ-008 Internal register number, 16 bits: four hex digits shown on the display; it is named exactly `number` so benches can probe it.

Function
REQ-009 key_in SHALL pass through a 2-flop synchronizer before any use.
REQ-010 Keypad map, key_in to hex value:
- 0000=1, 0001=2, 0010=3, 0011=A
- 0100=4, 0101=5, 0110=6, 0111=B
- 1000=7, 1001=8, 1010=9, 1011=C
- 1100=E, 1101=0, 1110=F
- 1111 = no key; digit D is not enterable.
REQ-011 Debounce states: IDLE and PRESSED.
- Any change of the synchronized code restarts the stability counter.
- In IDLE, a non-1111 code stable for DEBOUNCE_CYCLES cycles SHALL emit one single-cycle key event and move to PRESSED.
- In PRESSED, 1111 stable for DEBOUNCE_CYCLES cycles SHALL return to IDLE.
- In PRESSED, a different non-1111 code SHALL NOT emit an event; the key must be released first.
REQ-012 On a key event, number SHALL update in the following cycle to {number[11:0], mapped digit}; the oldest digit is discarded.
REQ-013 Press-to-update latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, ±1 cycle.
REQ-014 A held key SHALL produce exactly one event regardless of hold duration.
REQ-015 Glitches shorter than DEBOUNCE_CYCLES cycles, in either direction, SHALL produce no event and no state change.
REQ-016 Display scan:
- A refresh counter SHALL advance the digit index 0→1→2→3→0 every REFRESH_DIV cycles.
- an SHALL have only bit[index] low.
- seg SHALL show number[4*index+3 : 4*index].
REQ-017 Hex to seg mapping, active-low {g..a}:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-018 seg and an SHALL be registered so they change glitch-free, in the same cycle, together.

Reset
REQ-019 While rst=0, all of the following SHALL hold, asynchronously:
- number = 16'h0000
- debounce FSM = IDLE, counters = 0, synchronizer flops = 1111
- digit index = 0, an = 1110, seg = 1000000
REQ-020 Reset asserted mid-press SHALL discard the press. After release of reset, a key still held SHALL need a full DEBOUNCE_CYCLES to register.

Structure
REQ-021 Shared package kd_pkg SHALL hold:
- NO_KEY = 4'b1111
- the keypad map function
- the 16-entry 7-segment pattern table
- default parameter constants
REQ-022 Debounce and event logic SHALL be one sub-module, kd_debounce (clk, rst, code in, event out, value out). Mapping, shift register and display scan SHALL stay in top_kd.

Verification
REQ-023 Reset: hold rst=0 for 100 ns with key_in=1111 → number=0000, an=1110, seg=1000000 after release.
REQ-024 Press 0010 for 2000 ns, then 1111 for 2000 ns → number=0003 within 2+DEBOUNCE_CYCLES+2 cycles; exactly one update.
REQ-025 Then press 1101 for 2000 ns and release → number=0030; across a full scan, the an=1101 slot shows seg=0110000 and the an=1110 slot shows seg=1000000.
REQ-026 Glitch: 1000 held for DEBOUNCE_CYCLES−2 cycles, then 1111 → number unchanged. Hold 1000 for 1000 cycles → exactly one shift-in of 7.
REQ-027 Five presses 1,2,3,4,5 (codes 0000,0001,0010,0100,0101) → number=2345 (wrap discards the oldest digit). Assert rst mid-press → number=0000 with no event.
REQ-028 Over one full refresh cycle, an SHALL visit 1110, 1101, 1011, 0111 in order, each for REFRESH_DIV cycles.
